multiport_reg_file: RTL and testbench

- Parametrised successor to the core register file.
- Provides N asynchronous read ports and two synchronous write ports:
  - port A: ALU/execute writeback.
  - port B: load/memory writeback.
- Includes a per-register pending-write scoreboard so the hazard unit can stall on registers with outstanding writes.
- Sits between decode (reads, issue marking) and the writeback stages.

---
 rtl/multiport_reg_file.sv | 98 +++++++++
 tb/tb_multiport_reg_file.sv | 208 ++++++++++++++++++++
 2 files changed

// File: rtl/multiport_reg_file.sv
// Multi-port register file: ReadPorts async reads, two sync write ports (A=execute, B=load)
// and a per-register pending-write scoreboard. Define REGFILE_BYPASS_EN for same-cycle write-to-read forwarding.
module multiport_reg_file #(
  parameter int WordLen   = 32,
  parameter int WordCount = 16,
  parameter int ReadPorts = 3,
  parameter int ZeroReg   = 1,
  localparam int AddrLen  = $clog2(WordCount)
) (
  input  logic                           clk,
  input  logic                           rst,
  input  logic [ReadPorts*AddrLen-1:0]   readRegister,
  output logic [ReadPorts*WordLen-1:0]   readData,
  input  logic                           wrEnA,
  input  logic [AddrLen-1:0]             wrAddrA,
  input  logic [WordLen-1:0]             wrDataA,
  input  logic                           wrEnB,
  input  logic [AddrLen-1:0]             wrAddrB,
  input  logic [WordLen-1:0]             wrDataB,
  input  logic                           issueEn,
  input  logic [AddrLen-1:0]             issueAddr,
  output logic [WordCount-1:0]           busy,
  output logic [ReadPorts-1:0]           readBusy,
  output logic                           writeConflict
);

  logic [WordLen-1:0] regs [WordCount];
  logic               weA;
  logic               weB;
  logic               issueOk;
  logic               sameAddr;

  // Effective enables: nothing lands while in reset, and r0 is read-only when ZeroReg is set.
  assign weA      = rst && wrEnA   && !(ZeroReg != 0 && wrAddrA   == '0);
  assign weB      = rst && wrEnB   && !(ZeroReg != 0 && wrAddrB   == '0);
  assign issueOk  = rst && issueEn && !(ZeroReg != 0 && issueAddr == '0);
  assign sameAddr = (wrAddrA == wrAddrB);

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      for (int r = 0; r < WordCount; r++) regs[r] <= '0;
    end else begin
      if (weA && !(weB && sameAddr)) regs[wrAddrA] <= wrDataA;
      if (weB)                       regs[wrAddrB] <= wrDataB;
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      writeConflict <= 1'b0;
    end else begin
      writeConflict <= weA && weB && sameAddr;
    end
  end

  // Issue beats a same-cycle writeback: the newly issued instruction now owns the register.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      busy <= '0;
    end else begin
      for (int r = 0; r < WordCount; r++) begin
        if (issueOk && issueAddr == AddrLen'(r)) begin
          busy[r] <= 1'b1;
        end else if ((weA && wrAddrA == AddrLen'(r)) || (weB && wrAddrB == AddrLen'(r))) begin
          busy[r] <= 1'b0;
        end
      end
    end
  end

  for (genvar k = 0; k < ReadPorts; k++) begin : gRead
    logic [AddrLen-1:0] addr;
    logic [WordLen-1:0] data;
    logic               rdBusy;

    assign addr = readRegister[k*AddrLen +: AddrLen];

    always_comb begin
      data   = regs[addr];
      rdBusy = busy[addr];
`ifdef REGFILE_BYPASS_EN
      if (weA && wrAddrA == addr) begin
        data   = wrDataA;
        rdBusy = 1'b0;
      end
      if (weB && wrAddrB == addr) begin
        data   = wrDataB;
        rdBusy = 1'b0;
      end
`endif
      if (ZeroReg != 0 && addr == '0) data = '0;
    end

    assign readData[k*WordLen +: WordLen] = data;
    assign readBusy[k]                    = rdBusy;
  end

endmodule

// File: tb/tb_multiport_reg_file.sv
// Directed bench for multiport_reg_file: default build, a ZeroReg=0 copy and a 32x16b 4-port copy.
module tb_multiport_reg_file;
  logic clk = 1'b0;
  logic rst = 1'b0;
  int   total = 0;
  int   bad   = 0;
  logic byp;

  // default instance: WordLen 32, WordCount 16, ReadPorts 3, ZeroReg 1
  logic [11:0] rr;
  logic [95:0] rd;
  logic        weA, weB, iss;
  logic [3:0]  waA, waB, ia;
  logic [31:0] wdA, wdB;
  logic [15:0] bsy;
  logic [2:0]  rb;
  logic        conf;

  // ZeroReg=0 instance
  logic [3:0]  zRr, zWaA, zWaB, zIa;
  logic [31:0] zRd, zWdA, zWdB;
  logic        zWeA, zWeB, zIss, zRb, zConf;
  logic [15:0] zBsy;

  // WordCount 32, ReadPorts 4, WordLen 16 instance
  logic [19:0] pRr;
  logic [63:0] pRd;
  logic        pWeA, pWeB, pIss, pConf;
  logic [4:0]  pWaA, pWaB, pIa;
  logic [15:0] pWdA, pWdB;
  logic [31:0] pBsy;
  logic [3:0]  pRb;

  multiport_reg_file u0 (
    .clk(clk), .rst(rst), .readRegister(rr), .readData(rd),
    .wrEnA(weA), .wrAddrA(waA), .wrDataA(wdA),
    .wrEnB(weB), .wrAddrB(waB), .wrDataB(wdB),
    .issueEn(iss), .issueAddr(ia), .busy(bsy), .readBusy(rb), .writeConflict(conf));

  multiport_reg_file #(.ReadPorts(1), .ZeroReg(0)) u1 (
    .clk(clk), .rst(rst), .readRegister(zRr), .readData(zRd),
    .wrEnA(zWeA), .wrAddrA(zWaA), .wrDataA(zWdA),
    .wrEnB(zWeB), .wrAddrB(zWaB), .wrDataB(zWdB),
    .issueEn(zIss), .issueAddr(zIa), .busy(zBsy), .readBusy(zRb), .writeConflict(zConf));

  multiport_reg_file #(.WordLen(16), .WordCount(32), .ReadPorts(4)) u2 (
    .clk(clk), .rst(rst), .readRegister(pRr), .readData(pRd),
    .wrEnA(pWeA), .wrAddrA(pWaA), .wrDataA(pWdA),
    .wrEnB(pWeB), .wrAddrB(pWaB), .wrDataB(pWdB),
    .issueEn(pIss), .issueAddr(pIa), .busy(pBsy), .readBusy(pRb), .writeConflict(pConf));

  always #5 clk = ~clk;

  task automatic checkVal(input string tag, input logic [63:0] got, input logic [63:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s: got=%h want=%h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic idle();
    weA = 1'b0; weB = 1'b0; iss = 1'b0;
  endtask

  initial begin
`ifdef REGFILE_BYPASS_EN
    byp = 1'b1;
`else
    byp = 1'b0;
`endif
    rr = '0; idle(); waA = '0; waB = '0; ia = '0; wdA = '0; wdB = '0;
    zRr = '0; zWeA = 1'b0; zWeB = 1'b0; zIss = 1'b0; zWaA = '0; zWaB = '0; zIa = '0; zWdA = '0; zWdB = '0;
    pRr = '0; pWeA = 1'b0; pWeB = 1'b0; pIss = 1'b0; pWaA = '0; pWaB = '0; pIa = '0; pWdA = '0; pWdB = '0;
    tick(); tick();
    rst = 1'b1;

    // reset asserted mid-operation
    weA = 1'b1; waA = 4'd3; wdA = 32'h55; iss = 1'b1; ia = 4'd4; rr[3:0] = 4'd3;
    tick();
    iss = 1'b0;
    checkVal("preRstR3", rd[31:0], 32'h55);
    checkVal("preRstBusy4", bsy[4], 1'b1);
    wdA = 32'h99; rst = 1'b0;
    #1;
    checkVal("rstData0", rd, 96'h0);
    checkVal("rstBusy", bsy, 16'h0);
    checkVal("rstConf", conf, 1'b0);
    tick();
    checkVal("rstHoldR3", rd[31:0], 32'h0);
    rst = 1'b1; wdA = 32'h11;
    tick();
    idle();
    checkVal("postRstR3", rd[31:0], 32'h11);

    // dual write, same address
    weA = 1'b1; waA = 4'd5; wdA = 32'hAAAA0000;
    weB = 1'b1; waB = 4'd5; wdB = 32'h0000BBBB;
    tick();
    idle(); rr[3:0] = 4'd5; rr[7:4] = 4'd5;
    #1;
    checkVal("dualP0", rd[31:0], 32'h0000BBBB);
    checkVal("dualP1", rd[63:32], 32'h0000BBBB);
    checkVal("dualConf1", conf, 1'b1);
    tick();
    checkVal("dualConf2", conf, 1'b0);
    // dual write, different addresses
    weA = 1'b1; waA = 4'd6; wdA = 32'h1; weB = 1'b1; waB = 4'd7; wdB = 32'h2;
    tick();
    idle(); rr[3:0] = 4'd6; rr[7:4] = 4'd7;
    #1;
    checkVal("diffConf", conf, 1'b0);
    checkVal("diffR6", rd[31:0], 32'h1);
    checkVal("diffR7", rd[63:32], 32'h2);
    checkVal("diffBusy", bsy, 16'h0);

    // zero register
    weA = 1'b1; waA = 4'd0; wdA = 32'hFFFFFFFF; iss = 1'b1; ia = 4'd0; rr[3:0] = 4'd0;
    #1;
    checkVal("zeroSame", rd[31:0], 32'h0);
    tick();
    idle();
    #1;
    checkVal("zeroRd", rd[31:0], 32'h0);
    checkVal("zeroBusy", bsy[0], 1'b0);
    weA = 1'b1; weB = 1'b1; waA = 4'd0; waB = 4'd0; wdB = 32'h5;
    tick();
    idle();
    checkVal("zeroConf", conf, 1'b0);
    checkVal("zeroRd2", rd[31:0], 32'h0);

    // scoreboard
    iss = 1'b1; ia = 4'd7;
    tick();
    idle(); rr[7:4] = 4'd7;
    #1;
    checkVal("sbBusy7", bsy[7], 1'b1);
    checkVal("sbRdBusy1", rb[1], 1'b1);
    weB = 1'b1; waB = 4'd7; wdB = 32'h77; iss = 1'b1; ia = 4'd7;
    tick();
    idle();
    checkVal("sbIssWins", bsy[7], 1'b1);
    checkVal("sbData", rd[63:32], 32'h77);
    weA = 1'b1; waA = 4'd7; wdA = 32'h78;
    tick();
    idle();
    checkVal("sbClr", bsy, 16'h0);
    checkVal("sbRdBusyClr", rb[1], 1'b0);

    // same-cycle read of a written register
    iss = 1'b1; ia = 4'd2;
    tick();
    idle();
    checkVal("bpBusy2", bsy[2], 1'b1);
    weA = 1'b1; waA = 4'd2; wdA = 32'h1234; rr[3:0] = 4'd2;
    #1;
    checkVal("bpSame", rd[31:0], byp ? 32'h1234 : 32'h0);
    checkVal("bpRdBusy", rb[0], byp ? 1'b0 : 1'b1);
    tick();
    idle();
    checkVal("bpNext", rd[31:0], 32'h1234);
    checkVal("bpBusyClr", bsy[2], 1'b0);
    weA = 1'b1; waA = 4'd9; wdA = 32'hA; weB = 1'b1; waB = 4'd9; wdB = 32'hB; rr[11:8] = 4'd9;
    #1;
    checkVal("bpPrioB", rd[95:64], byp ? 32'hB : 32'h0);
    tick();
    idle();
    checkVal("prioNext", rd[95:64], 32'hB);
    checkVal("prioConf", conf, 1'b1);

    // ZeroReg=0: r0 is an ordinary register
    zWeA = 1'b1; zWaA = 4'd0; zWdA = 32'hFFFFFFFF; zIss = 1'b1; zIa = 4'd0;
    tick();
    zWeA = 1'b0; zIss = 1'b0;
    #1;
    checkVal("z0Rd", zRd, 32'hFFFFFFFF);
    checkVal("z0Busy", zBsy, 16'h1);
    checkVal("z0RdBusy", zRb, 1'b1);
    checkVal("z0Conf", zConf, 1'b0);

    // 32 x 16-bit, 4 read ports
    for (int i = 0; i < 32; i++) begin
      pWeA = 1'b1; pWaA = 5'(i); pWdA = 16'(16'h5000 + i * 7);
      tick();
    end
    pWeA = 1'b0;
    for (int g = 0; g < 8; g++) begin
      for (int j = 0; j < 4; j++) pRr[j*5 +: 5] = 5'(g * 4 + j);
      #1;
      for (int j = 0; j < 4; j++) begin
        int a;
        a = g * 4 + j;
        checkVal($sformatf("wide_r%0d", a), pRd[j*16 +: 16], (a == 0) ? 16'h0 : 16'(16'h5000 + a * 7));
      end
    end
    checkVal("wideBusy", pBsy, 32'h0);
    checkVal("wideRdBusy", pRb, 4'h0);
    checkVal("wideConf", pConf, 1'b0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
